// File: rtl/uart_program_loader_pkg.sv
// rtl/uart_program_loader_pkg.sv - shared constants and state encodings for the UART program loader
package uart_program_loader_pkg;

  localparam logic [7:0] HEADER_BYTE     = 8'hA5;
  localparam int         CHECKSUM_W      = 8;
  localparam int         DEFAULT_INSTR_W = 28;
  localparam int         DEFAULT_ADDR_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    WORD,
    CHK,
    DONE,
    ERROR
  } loaderState_t;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver: synchronizer, mid-bit sampling, stop-bit check
module uart_rx_8n1
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRx,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic       oFrameErr
);

  localparam int TIMER_W = $clog2(CLK_DIV);

  rxState_t           state, stateNext;
  logic               rxMeta, rxSync, rxPrev;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [2:0]         bitIdx, bitIdxNext;
  logic [7:0]         shiftReg, shiftNext, byteNext;
  logic               validNext, frameErrNext;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      rxPrev     <= 1'b1;
      state      <= RX_HUNT;
      timer      <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      oByte      <= '0;
      oByteValid <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      rxMeta     <= iRx;
      rxSync     <= rxMeta;
      rxPrev     <= rxSync;
      state      <= stateNext;
      timer      <= timerNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftNext;
      oByte      <= byteNext;
      oByteValid <= validNext;
      oFrameErr  <= frameErrNext;
    end
  end

  // Timer free-runs down outside HUNT; every sample point reloads it.
  always_comb begin
    stateNext    = state;
    timerNext    = timer;
    bitIdxNext   = bitIdx;
    shiftNext    = shiftReg;
    byteNext     = oByte;
    validNext    = 1'b0;
    frameErrNext = 1'b0;
    if (state != RX_HUNT) timerNext = timer - 1'b1;
    unique case (state)
      RX_HUNT: begin
        if (rxPrev && !rxSync) begin
          stateNext = RX_START;
          timerNext = TIMER_W'(CLK_DIV / 2 - 1);
        end
      end
      RX_START: begin
        if (timer == '0) begin
          if (rxSync) begin
            stateNext = RX_HUNT;
          end else begin
            stateNext  = RX_DATA;
            timerNext  = TIMER_W'(CLK_DIV - 1);
            bitIdxNext = '0;
          end
        end
      end
      RX_DATA: begin
        if (timer == '0) begin
          shiftNext  = {rxSync, shiftReg[7:1]};
          timerNext  = TIMER_W'(CLK_DIV - 1);
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == 3'd7) stateNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer == '0) begin
          stateNext = RX_HUNT;
          if (rxSync) begin
            byteNext  = shiftReg;
            validNext = 1'b1;
          end else begin
            frameErrNext = 1'b1;
          end
        end
      end
      default: stateNext = RX_HUNT;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART boot loader writing 4-byte words into instruction RAM
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int INSTR_W   = DEFAULT_INSTR_W,
  parameter int MAX_WORDS = 256
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iRx,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oCpuReset,
  output logic               oDone,
  output logic               oError,
  output logic [ADDR_W-1:0]  oWordCount
);

  logic [7:0] rxByte;
  logic       rxValid, rxFrameErr;

  uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) rx (
    .Clock      (Clock),
    .Reset      (Reset),
    .iRx        (iRx),
    .oByte      (rxByte),
    .oByteValid (rxValid),
    .oFrameErr  (rxFrameErr)
  );

  loaderState_t state, stateNext;
  logic [7:0]   countLo;
  logic [15:0]  wordTotal, rxCount;
  logic [23:0]  wordShift;
  logic [31:0]  fullWord;
  logic [1:0]   byteIdx;
  logic         startLoad, takeCountLo, takeCountHi, takeWordByte, writeWord, lastWord;

  assign rxCount  = {rxByte, countLo};
  assign fullWord = {wordShift, rxByte};
  assign lastWord = (17'(oWordCount) + 17'd1) == 17'(wordTotal);

`ifdef LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] checksum;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      checksum <= '0;
    end else if (startLoad) begin
      checksum <= '0;
    end else if (takeCountLo || takeCountHi || takeWordByte) begin
      checksum <= checksum ^ rxByte;
    end
  end
`endif

  always_comb begin
    stateNext    = state;
    startLoad    = 1'b0;
    takeCountLo  = 1'b0;
    takeCountHi  = 1'b0;
    takeWordByte = 1'b0;
    writeWord    = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (rxValid && rxByte == HEADER_BYTE) begin
          stateNext = CNT_LO;
          startLoad = 1'b1;
        end
      end
      CNT_LO: begin
        if (rxFrameErr) begin
          stateNext = ERROR;
        end else if (rxValid) begin
          takeCountLo = 1'b1;
          stateNext   = CNT_HI;
        end
      end
      CNT_HI: begin
        if (rxFrameErr) begin
          stateNext = ERROR;
        end else if (rxValid) begin
          takeCountHi = 1'b1;
          if (rxCount == '0)                    stateNext = CHK;
          else if (rxCount > 16'(MAX_WORDS))    stateNext = ERROR;
          else                                  stateNext = WORD;
        end
      end
      WORD: begin
        if (rxFrameErr) begin
          stateNext = ERROR;
        end else if (rxValid) begin
          takeWordByte = 1'b1;
          if (byteIdx == 2'd3) begin
            writeWord = 1'b1;
            if (lastWord) stateNext = CHK;
          end
        end
      end
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (rxFrameErr)   stateNext = ERROR;
        else if (rxValid) stateNext = (rxByte == checksum) ? DONE : ERROR;
`else
        stateNext = DONE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  // Address and data only move on a write so the RAM side sees stable values between strobes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      countLo       <= '0;
      wordTotal     <= '0;
      wordShift     <= '0;
      byteIdx       <= '0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oInstruction  <= '0;
      oWordCount    <= '0;
    end else begin
      state        <= stateNext;
      oWriteEnable <= writeWord;
      if (startLoad) begin
        oWordCount <= '0;
        byteIdx    <= '0;
      end
      if (takeCountLo) countLo   <= rxByte;
      if (takeCountHi) wordTotal <= rxCount;
      if (takeWordByte) begin
        wordShift <= fullWord[23:0];
        byteIdx   <= byteIdx + 2'd1;
      end
      if (writeWord) begin
        oWriteAddress <= oWordCount;
        oInstruction  <= fullWord[INSTR_W-1:0];
        oWordCount    <= oWordCount + 1'b1;
      end
    end
  end

  assign oDone     = (state == DONE);
  assign oError    = (state == ERROR);
  assign oCpuReset = (state != DONE);

endmodule
